// File: rtl/synth_pkg.sv
// synth_pkg: shared constants, types and slot/bit mapping helpers
// for the synthesizer voice allocator.
package synth_pkg;
  localparam int NOTE_W       = 4;
  localparam int SLOTS_PER_CH = 3;
  localparam int NUM_CH       = 2;
  localparam int NUM_SLOTS    = NUM_CH * SLOTS_PER_CH;

  typedef logic [NOTE_W-1:0] note_t;
  typedef logic [1:0]        rank_t;
  typedef logic [2:0]        sidx_t;

  localparam note_t NOTE_SILENT = '0;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    COMMIT
  } state_t;

  function automatic sidx_t slot_idx(
    input logic       ch,
    input logic [1:0] s
  );
    return ch ? sidx_t'(s) + sidx_t'(SLOTS_PER_CH)
              : sidx_t'(s);
  endfunction

  // Slot 0 sits in the MSB nibble of each channel half.
  function automatic logic [4:0] voice_off(
    input logic       ch,
    input logic [1:0] s
  );
    return 5'(NOTE_W * SLOTS_PER_CH * int'(ch)
            + NOTE_W * (SLOTS_PER_CH - 1 - int'(s)));
  endfunction
endpackage

// File: rtl/synth_hold_tick.sv
// synth_hold_tick: hold-time prescaler, one-cycle tick every
// TICK_DIV clocks.
module synth_hold_tick #(
  parameter int TICK_DIV = 480000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == TERM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/synth_voice_allocator.sv
// synth_voice_allocator: 2x3 voice slots with LRU stealing,
// note on/off events and timed auto-release.
module synth_voice_allocator
  import synth_pkg::*;
#(
  parameter int TICK_DIV   = 480000,
  parameter int HOLD_TICKS = 50,
  parameter int HOLD_W     = 8
) (
  input  logic        MasterCLK,
  input  logic        Reset,
  input  logic        EventValid,
  output logic        EventReady,
  input  logic        EventChannel,
  input  logic [3:0]  EventNote,
  input  logic        EventOn,
  input  logic        AllOff,
  output logic [23:0] VoiceData,
  output logic        VoiceUpdate,
  output logic        StealPulse
);
  typedef logic [HOLD_W-1:0] hold_t;
  localparam hold_t HOLD_LOAD = hold_t'(HOLD_TICKS);

  state_t state;
  logic   ch_q;
  logic   on_q;
  note_t  note_q;

  note_t note_r [NUM_SLOTS];
  hold_t hold_r [NUM_SLOTS];
  rank_t rank_r [NUM_SLOTS];
  note_t note_n [NUM_SLOTS];
  hold_t hold_n [NUM_SLOTS];

  logic       hit_q, free_q;
  logic [1:0] hit_s, free_s, vic_s;
  logic       hit_c, free_c;
  logic [1:0] hit_sc, free_sc, vic_sc;

  logic       tick;
  logic       wr, bump, steal_c, changed;
  logic [1:0] wr_s;
  sidx_t      wr_i;
  note_t      wr_note;
  hold_t      wr_hold;

  synth_hold_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (MasterCLK),
    .rst_n(Reset),
    .tick (tick)
  );

  // Descending scan so the lowest matching slot wins.
  always_comb begin
    hit_c   = 1'b0;
    hit_sc  = '0;
    free_c  = 1'b0;
    free_sc = '0;
    vic_sc  = '0;
    for (int s = SLOTS_PER_CH - 1; s >= 0; s--) begin
      if (note_r[slot_idx(ch_q, 2'(s))] == note_q) begin
        hit_c  = 1'b1;
        hit_sc = 2'(s);
      end
      if (note_r[slot_idx(ch_q, 2'(s))] == NOTE_SILENT) begin
        free_c  = 1'b1;
        free_sc = 2'(s);
      end
      if (rank_r[slot_idx(ch_q, 2'(s))] == 2'd2) begin
        vic_sc = 2'(s);
      end
    end
  end

  always_comb begin
    wr      = 1'b0;
    bump    = 1'b0;
    steal_c = 1'b0;
    wr_s    = '0;
    wr_note = NOTE_SILENT;
    wr_hold = '0;
    if (state == COMMIT && !AllOff
        && note_q != NOTE_SILENT) begin
      if (on_q) begin
        wr      = 1'b1;
        bump    = 1'b1;
        wr_hold = HOLD_LOAD;
        if (hit_q) begin
          wr_s    = hit_s;
          wr_note = note_r[slot_idx(ch_q, hit_s)];
        end else if (free_q) begin
          wr_s    = free_s;
          wr_note = note_q;
        end else begin
          wr_s    = vic_s;
          wr_note = note_q;
          steal_c = 1'b1;
        end
      end else if (hit_q) begin
        wr   = 1'b1;
        wr_s = hit_s;
      end
    end
  end

  assign wr_i = slot_idx(ch_q, wr_s);

  // Priority: AllOff, then the commit write, then expiry ticks.
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      note_n[i] = note_r[i];
      hold_n[i] = hold_r[i];
      if (tick && note_r[i] != NOTE_SILENT
          && hold_r[i] != '0) begin
        if (hold_r[i] == hold_t'(1)) begin
          note_n[i] = NOTE_SILENT;
          hold_n[i] = '0;
        end else begin
          hold_n[i] = hold_r[i] - hold_t'(1);
        end
      end
      if (wr && wr_i == 3'(i)) begin
        note_n[i] = wr_note;
        hold_n[i] = wr_hold;
      end
      if (AllOff) begin
        note_n[i] = NOTE_SILENT;
        hold_n[i] = '0;
      end
      if (note_n[i] != note_r[i]) begin
        changed = 1'b1;
      end
    end
  end

  always_comb begin
    VoiceData = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int s = 0; s < SLOTS_PER_CH; s++) begin
        VoiceData[voice_off(1'(c), 2'(s)) +: NOTE_W] =
          note_r[slot_idx(1'(c), 2'(s))];
      end
    end
  end

  always_ff @(posedge MasterCLK) begin
    if (!Reset) begin
      state       <= IDLE;
      EventReady  <= 1'b0;
      ch_q        <= 1'b0;
      on_q        <= 1'b0;
      note_q      <= NOTE_SILENT;
      hit_q       <= 1'b0;
      free_q      <= 1'b0;
      hit_s       <= '0;
      free_s      <= '0;
      vic_s       <= '0;
      VoiceUpdate <= 1'b0;
      StealPulse  <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        note_r[i] <= NOTE_SILENT;
        hold_r[i] <= '0;
        rank_r[i] <= rank_t'(i % SLOTS_PER_CH);
      end
    end else begin
      VoiceUpdate <= changed;
      StealPulse  <= steal_c;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        note_r[i] <= note_n[i];
        hold_r[i] <= hold_n[i];
      end
      if (bump) begin
        for (int s = 0; s < SLOTS_PER_CH; s++) begin
          if (slot_idx(ch_q, 2'(s)) == wr_i) begin
            rank_r[wr_i] <= '0;
          end else if (rank_r[slot_idx(ch_q, 2'(s))]
                       < rank_r[wr_i]) begin
            rank_r[slot_idx(ch_q, 2'(s))] <=
              rank_r[slot_idx(ch_q, 2'(s))] + 2'd1;
          end
        end
      end
      unique case (state)
        IDLE: begin
          if (EventValid && EventReady) begin
            ch_q       <= EventChannel;
            note_q     <= EventNote;
            on_q       <= EventOn;
            state      <= LOOKUP;
            EventReady <= 1'b0;
          end else begin
            EventReady <= 1'b1;
          end
        end
        LOOKUP: begin
          hit_q  <= hit_c;
          hit_s  <= hit_sc;
          free_q <= free_c;
          free_s <= free_sc;
          vic_s  <= vic_sc;
          state  <= COMMIT;
        end
        COMMIT: begin
          state      <= IDLE;
          EventReady <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          EventReady <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_synth_voice_allocator.sv
// tb_synth_voice_allocator: directed vector table on a slow-tick
// instance plus a reference model tracking a fast-tick instance.
module tb_synth_voice_allocator;
  localparam int TD = 4;
  localparam int HT = 2;

  logic        MasterCLK = 1'b0;
  logic        Reset = 1'b0;
  logic        EventValid = 1'b0;
  logic        EventChannel = 1'b0;
  logic [3:0]  EventNote = '0;
  logic        EventOn = 1'b0;
  logic        AllOff = 1'b0;

  logic        rdy_a, vu_a, st_a;
  logic [23:0] vd_a;
  logic        rdy_h, vu_h, st_h;
  logic [23:0] vd_h;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 MasterCLK = ~MasterCLK;

  synth_voice_allocator dut (
    .MasterCLK   (MasterCLK),
    .Reset       (Reset),
    .EventValid  (EventValid),
    .EventReady  (rdy_a),
    .EventChannel(EventChannel),
    .EventNote   (EventNote),
    .EventOn     (EventOn),
    .AllOff      (AllOff),
    .VoiceData   (vd_a),
    .VoiceUpdate (vu_a),
    .StealPulse  (st_a)
  );

  synth_voice_allocator #(
    .TICK_DIV  (TD),
    .HOLD_TICKS(HT)
  ) dut_h (
    .MasterCLK   (MasterCLK),
    .Reset       (Reset),
    .EventValid  (EventValid),
    .EventReady  (rdy_h),
    .EventChannel(EventChannel),
    .EventNote   (EventNote),
    .EventOn     (EventOn),
    .AllOff      (AllOff),
    .VoiceData   (vd_h),
    .VoiceUpdate (vu_h),
    .StealPulse  (st_h)
  );

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               nm, got, exp, $time);
    end
  endtask

  // Reference model: per-slot notes and hold counts, recency kept
  // as allocation timestamps (smallest stamp = oldest).
  int mnote [2][3];
  int mhold [2][3];
  int mstamp[2][3];
  int mclk = 0, cyc = 0, mph = 0;
  int mch = 0, mnt = 0, mon = 0;
  int mm = -1, mf = -1, mv = 0;
  bit mrdy = 1'b0;
  logic [31:0] mexp = '0;

  task automatic model_edge();
    int nn[2][3];
    int nh[2][3];
    int x, v;
    bit tk, st, vu;
    logic [23:0] vd;
    st = 1'b0;
    vu = 1'b0;
    if (!Reset) begin
      for (int c = 0; c < 2; c++)
        for (int s = 0; s < 3; s++) begin
          mnote[c][s] = 0;
          mhold[c][s] = 0;
          mstamp[c][s] = -s;
        end
      mph = 0;
      mrdy = 1'b0;
      cyc = 0;
      mexp = '0;
      return;
    end
    tk = (cyc % TD) == TD - 1;
    cyc++;
    nn = mnote;
    nh = mhold;
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 3; s++)
        if (tk && mnote[c][s] != 0) begin
          if (mhold[c][s] > 1) nh[c][s] = mhold[c][s] - 1;
          else if (mhold[c][s] == 1) begin
            nn[c][s] = 0;
            nh[c][s] = 0;
          end
        end
    if (mph == 0) begin
      if (EventValid && mrdy) begin
        mch = int'(EventChannel);
        mnt = int'(EventNote);
        mon = int'(EventOn);
        mph = 1;
        mrdy = 1'b0;
      end else begin
        mrdy = 1'b1;
      end
    end else if (mph == 1) begin
      mm = -1;
      mf = -1;
      mv = 0;
      for (int s = 2; s >= 0; s--) begin
        if (mnote[mch][s] == mnt) mm = s;
        if (mnote[mch][s] == 0) mf = s;
      end
      for (int s = 1; s < 3; s++)
        if (mstamp[mch][s] < mstamp[mch][mv]) mv = s;
      mph = 2;
    end else begin
      mph = 0;
      mrdy = 1'b1;
      if (!AllOff && mnt != 0) begin
        if (mon != 0) begin
          if (mm >= 0) begin
            x = mm;
            v = mnote[mch][mm];
          end else if (mf >= 0) begin
            x = mf;
            v = mnt;
          end else begin
            x = mv;
            v = mnt;
            st = 1'b1;
          end
          nn[mch][x] = v;
          nh[mch][x] = HT;
          mclk++;
          mstamp[mch][x] = mclk;
        end else if (mm >= 0) begin
          nn[mch][mm] = 0;
          nh[mch][mm] = 0;
        end
      end
    end
    vd = '0;
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 3; s++) begin
        if (AllOff) begin
          nn[c][s] = 0;
          nh[c][s] = 0;
        end
        if (nn[c][s] != mnote[c][s]) vu = 1'b1;
        vd[12*c + 4*(2-s) +: 4] = 4'(nn[c][s]);
      end
    mnote = nn;
    mhold = nh;
    mexp = {5'b0, vd, vu, st, mrdy};
  endtask

  always @(posedge MasterCLK) model_edge();

  always @(negedge MasterCLK)
    if (chk_en)
      chk("model_h", {5'b0, vd_h, vu_h, st_h, rdy_h}, mexp);

  task automatic send(input bit ch, input int note, input bit on);
    int w = 0;
    while (!rdy_a && w < 20) begin
      @(negedge MasterCLK);
      w++;
    end
    chk("ready_wait", 32'(rdy_a), 32'd1);
    EventValid = 1'b1;
    EventChannel = ch;
    EventNote = 4'(note);
    EventOn = on;
    @(negedge MasterCLK);
    EventValid = 1'b0;
    @(negedge MasterCLK);
    @(negedge MasterCLK);
  endtask

  typedef struct {
    bit          ch;
    int          note;
    bit          on;
    logic [23:0] vd;
    bit          vu;
    bit          st;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int k;
    tbl[0]  = '{1'b1, 13, 1'b1, 24'hD00000, 1'b1, 1'b0};
    tbl[1]  = '{1'b0,  4, 1'b1, 24'hD00400, 1'b1, 1'b0};
    tbl[2]  = '{1'b0,  6, 1'b1, 24'hD00460, 1'b1, 1'b0};
    tbl[3]  = '{1'b0,  8, 1'b1, 24'hD00468, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 11, 1'b1, 24'hD00B68, 1'b1, 1'b1};
    tbl[5]  = '{1'b0,  9, 1'b1, 24'hD00B98, 1'b1, 1'b1};
    tbl[6]  = '{1'b1,  5, 1'b1, 24'hD50B98, 1'b1, 1'b0};
    tbl[7]  = '{1'b0,  9, 1'b0, 24'hD50B08, 1'b1, 1'b0};
    tbl[8]  = '{1'b0,  9, 1'b1, 24'hD50B98, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 15, 1'b0, 24'hD50B98, 1'b0, 1'b0};
    tbl[10] = '{1'b0,  0, 1'b1, 24'hD50B98, 1'b0, 1'b0};
    tbl[11] = '{1'b0,  8, 1'b1, 24'hD50B98, 1'b0, 1'b0};
    tbl[12] = '{1'b0,  7, 1'b1, 24'hD50798, 1'b1, 1'b1};
    tbl[13] = '{1'b1, 13, 1'b0, 24'h050798, 1'b1, 1'b0};
    tbl[14] = '{1'b1,  1, 1'b1, 24'h150798, 1'b1, 1'b0};
    tbl[15] = '{1'b1,  2, 1'b1, 24'h152798, 1'b1, 1'b0};

    repeat (2) @(negedge MasterCLK);
    chk_en = 1'b1;
    chk("reset_vd", 32'(vd_a), 32'h0);
    chk("reset_flags", {29'b0, vu_a, st_a, rdy_a}, 32'h0);
    Reset = 1'b1;
    @(negedge MasterCLK);
    chk("ready_after_reset", 32'(rdy_a), 32'd1);

    for (int i = 0; i < 16; i++) begin
      send(tbl[i].ch, tbl[i].note, tbl[i].on);
      chk($sformatf("vec%0d_vd", i), 32'(vd_a), 32'(tbl[i].vd));
      chk($sformatf("vec%0d_vu", i), 32'(vu_a), 32'(tbl[i].vu));
      chk($sformatf("vec%0d_st", i), 32'(st_a), 32'(tbl[i].st));
    end

    AllOff = 1'b1;
    @(negedge MasterCLK);
    chk("alloff_vd", 32'(vd_a), 32'h0);
    chk("alloff_vu", 32'(vu_a), 32'd1);
    @(negedge MasterCLK);
    chk("alloff_held_vu", 32'(vu_a), 32'd0);
    AllOff = 1'b0;
    @(negedge MasterCLK);

    EventValid = 1'b1;
    EventChannel = 1'b0;
    EventNote = 4'd5;
    EventOn = 1'b1;
    @(negedge MasterCLK);
    chk("abort_accepted", 32'(rdy_a), 32'd0);
    EventValid = 1'b0;
    Reset = 1'b0;
    @(negedge MasterCLK);
    chk("abort_reset_vd", 32'(vd_a), 32'h0);
    chk("abort_reset_rdy", 32'(rdy_a), 32'd0);
    Reset = 1'b1;
    @(negedge MasterCLK);
    chk("abort_rdy", 32'(rdy_a), 32'd1);
    @(negedge MasterCLK);
    chk("abort_vd", 32'(vd_a), 32'h0);
    send(1'b0, 3, 1'b1);
    chk("post_abort_vd", 32'(vd_a), 32'h000300);

    send(1'b1, 1, 1'b1);
    chk("hold_loaded", 32'(vd_h[23:20]), 32'd1);
    k = 0;
    while (vd_h[23:20] != 4'd0 && k < 12) begin
      @(negedge MasterCLK);
      k++;
    end
    checks++;
    if (k < 5 || k > 8) begin
      failures++;
      $display("FAIL hold_expiry cycles=%0d required 5..8", k);
    end

    for (int i = 0; i < 1500; i++) begin
      @(negedge MasterCLK);
      Reset = ($urandom % 500) != 0;
      EventValid = ($urandom % 3) != 0;
      EventChannel = 1'($urandom % 2);
      EventNote = 4'($urandom % 6);
      EventOn = ($urandom % 10) < 7;
      AllOff = ($urandom % 50) == 0;
    end
    @(negedge MasterCLK);
    Reset = 1'b1;
    EventValid = 1'b0;
    AllOff = 1'b0;
    repeat (4) @(negedge MasterCLK);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
